// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: issues one RAM strobe per load/store, counts
// the configured latency, and stalls the pipeline until the access completes.
module data_mem_responder #(
  parameter int ADDR_WIDTH    = 15,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memread_mem,
  input  logic                  memwrite_mem,
  input  logic [31:0]           alu_result_mem,
  input  logic [31:0]           write_data_memory_mem,
  input  logic                  alu_ready,
  output logic [31:0]           data_from_memory_mem,
  output logic                  data_ready_mem,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic                  misaligned_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
  localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_store_q, is_store_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        req;
  logic        unused_addr_hi;

  assign req            = memread_mem | memwrite_mem;
  assign ram_addr       = alu_result_mem[ADDR_WIDTH+1:2];
  assign ram_wdata      = write_data_memory_mem;
  assign unused_addr_hi = ^alu_result_mem[31:ADDR_WIDTH+2];

  assign data_from_memory_mem = rdata_q;
  assign misaligned_err       = mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      is_store_q <= 1'b0;
      rdata_q    <= 32'd0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      rdata_q    <= rdata_d;
      mis_q      <= mis_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    is_store_d     = is_store_q;
    rdata_d        = rdata_q;
    mis_d          = mis_q;
    ram_en         = 1'b0;
    ram_we         = 1'b0;
    data_ready_mem = 1'b0;
    case (state_q)
      IDLE: begin
        data_ready_mem = ~req;
        if (req) begin
          ram_en     = 1'b1;
          ram_we     = memwrite_mem;
          is_store_d = memwrite_mem;
          cnt_d      = 4'd1;
          state_d    = WAIT;
          if (alu_result_mem[1:0] != 2'b00) mis_d = 1'b1;
        end
      end
      WAIT: begin
        if (is_store_q ? (cnt_q == WR_LAT) : (cnt_q == RD_LAT)) begin
          if (!is_store_q) rdata_d = ram_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        data_ready_mem = 1'b1;
        // Holding here keeps load data stable until the pipeline actually advances.
        if (alu_ready) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      ram_en         = 1'b0;
      ram_we         = 1'b0;
      data_ready_mem = 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, hand-written reset and
// misalignment sequence, then random accesses against a word-level memory model.
module tb_data_mem_responder;

  localparam int AW = 15;
  localparam int RL = 2;
  localparam int WL = 1;

  logic          clk, rst, memread_mem, memwrite_mem, alu_ready;
  logic [31:0]   alu_result_mem, write_data_memory_mem;
  logic [31:0]   data_from_memory_mem, ram_wdata, ram_rdata;
  logic          data_ready_mem, ram_en, ram_we, misaligned_err;
  logic [AW-1:0] ram_addr;

  data_mem_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
    .clk(clk), .rst(rst), .memread_mem(memread_mem), .memwrite_mem(memwrite_mem),
    .alu_result_mem(alu_result_mem), .write_data_memory_mem(write_data_memory_mem),
    .alu_ready(alu_ready), .data_from_memory_mem(data_from_memory_mem),
    .data_ready_mem(data_ready_mem), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .misaligned_err(misaligned_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears RL cycles after the strobe, garbage otherwise.
  logic [31:0] ram_mem [0:(1<<AW)-1];
  logic [31:0] pipe [RL];
  assign ram_rdata = pipe[RL-1];
  always @(posedge clk) begin
    if (ram_en && ram_we) ram_mem[ram_addr] <= ram_wdata;
    pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr] : $urandom;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end

  // Reference model: word-addressed memory contents and expected responder state.
  logic [31:0] ref_mem [int];
  logic [31:0] last_data;
  logic        mis_flag;
  int          n_cmp, n_err;

  function automatic logic [31:0] fill(input int k);
    return (k * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] ref_read(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : fill(k);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      memread_mem = 1'b0; memwrite_mem = 1'b0;
      alu_ready = 1'($urandom); alu_result_mem = $urandom;
      #4;
      chk("idle_rdy", data_ready_mem, 1'b1);
      chk("idle_en", ram_en, 1'b0);
      chk("idle_we", ram_we, 1'b0);
      chk("idle_data", data_from_memory_mem, last_data);
      chk("idle_err", misaligned_err, mis_flag);
      tick();
    end
  endtask

  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input int hold,
                            input logic [AW-1:0] exp_addr, input int exp_stall,
                            input logic [31:0] exp_data);
    logic mis_after;
    mis_after = mis_flag | (addr[1:0] != 2'b00);
    memread_mem = rd; memwrite_mem = wr;
    alu_result_mem = addr; write_data_memory_mem = wd;
    alu_ready = 1'($urandom);
    #4;
    chk("issue_en", ram_en, 1'b1);
    chk("issue_we", ram_we, wr);
    chk("issue_addr", ram_addr, exp_addr);
    if (wr) chk("issue_wdata", ram_wdata, wd);
    chk("issue_rdy", data_ready_mem, 1'b0);
    chk("issue_err", misaligned_err, mis_flag);
    tick();
    for (int c = 1; c < exp_stall; c++) begin
      alu_ready = 1'($urandom);
      #4;
      chk("wait_rdy", data_ready_mem, 1'b0);
      chk("wait_en", ram_en, 1'b0);
      tick();
    end
    for (int h = 0; h <= hold; h++) begin
      alu_ready = (h == hold);
      #4;
      chk("done_rdy", data_ready_mem, 1'b1);
      chk("done_en", ram_en, 1'b0);
      chk("done_data", data_from_memory_mem, exp_data);
      chk("done_err", misaligned_err, mis_after);
      tick();
    end
    mis_flag  = mis_after;
    last_data = exp_data;
  endtask

  typedef struct {
    logic          rd;
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    int            hold;
    int            gap;
    logic [AW-1:0] exp_addr;
    int            exp_stall;
    logic [31:0]   exp_data;
  } vec_t;

  vec_t vecs [5];

  initial begin
    n_cmp = 0; n_err = 0; last_data = 32'd0; mis_flag = 1'b0;
    for (int k = 0; k < (1 << AW); k++) ram_mem[k] = fill(k);
    for (int i = 0; i < RL; i++) pipe[i] = 32'd0;
    ram_mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;

    vecs[0] = '{1'b1, 1'b0, 32'h40, 32'h0,        0, 0, 15'h10, 3, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h08, 32'h12345678, 0, 1, 15'h02, 2, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h08, 32'h0,        3, 0, 15'h02, 3, 32'h12345678};
    vecs[3] = '{1'b1, 1'b1, 32'h44, 32'hCAFEF00D, 0, 0, 15'h11, 2, 32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 32'h44, 32'h0,        1, 2, 15'h11, 3, 32'hCAFEF00D};
    ref_mem[2] = 32'h12345678; ref_mem[17] = 32'hCAFEF00D;

    // Reset with a load pending
    rst = 1'b1; memread_mem = 1'b1; memwrite_mem = 1'b0; alu_ready = 1'b1;
    alu_result_mem = 32'h40; write_data_memory_mem = 32'd0;
    tick(); tick();
    #4;
    chk("rst_rdy", data_ready_mem, 1'b1);
    chk("rst_en", ram_en, 1'b0);
    chk("rst_data", data_from_memory_mem, 32'd0);
    chk("rst_err", misaligned_err, 1'b0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
                 vecs[i].exp_addr, vecs[i].exp_stall, vecs[i].exp_data);
      idle(vecs[i].gap);
    end

    // Misaligned load, then reset in WAIT abandons it
    memread_mem = 1'b1; memwrite_mem = 1'b0; alu_result_mem = 32'h43;
    #4;
    chk("mis_en", ram_en, 1'b1);
    chk("mis_addr", ram_addr, 15'h10);
    tick();
    #1;
    chk("mis_err", misaligned_err, 1'b1);
    chk("mis_wait_rdy", data_ready_mem, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_rdy", data_ready_mem, 1'b1);
    chk("midrst_en", ram_en, 1'b0);
    tick();
    rst = 1'b0;
    last_data = 32'd0; mis_flag = 1'b0;
    idle(4);

    // Random accesses against the model
    for (int i = 0; i < 60; i++) begin
      int op, k, stall;
      logic [31:0] a, wd, ed;
      logic rd, wr;
      op = $urandom_range(0, 3);
      a  = ($urandom & 32'hFFFE_0000) | (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      wd = $urandom;
      k  = int'(a[AW+1:2]);
      wr = (op >= 2);
      rd = (op == 1) || (op == 3);
      if (op == 0) begin
        idle(1);
      end else begin
        if (wr) begin
          ed = last_data; stall = WL + 1; ref_mem[k] = wd;
        end else begin
          ed = ref_read(k); stall = RL + 1;
        end
        run_access(rd, wr, a, wd, $urandom_range(0, 3), a[AW+1:2], stall, ed);
        idle($urandom_range(0, 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the core's MEM stage. It receives load/store requests from the EX/MEM pipeline register and drives a synchronous word-wide data RAM with configurable latency. It returns load data and generates data_ready_mem, which stalls the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. data_ready_mem is high for exactly one advancing cycle per completed access.

Parameters:
ADDR_WIDTH, 15, RAM word-address width; byte address bits [ADDR_WIDTH+1:2] are used.
READ_LATENCY, 2, cycles from the issue cycle until ram_rdata is valid; legal range 1..15.
WRITE_LATENCY, 1, wait cycles after the write issue cycle before completion; legal range 1..15.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
memread_mem  in  1  load request from EX/MEM
memwrite_mem  in  1  store request from EX/MEM
alu_result_mem  in  32  byte address
write_data_memory_mem  in  32  store data
alu_ready  in  1  ALU/FPU ready; the pipeline advances only when alu_ready and data_ready_mem are both 1
data_from_memory_mem  out  32  registered load data to MEM/WB
data_ready_mem  out  1  0 = stall pipeline
ram_en  out  1  RAM access strobe, one cycle per access
ram_we  out  1  RAM write enable, one cycle per store
ram_addr  out  ADDR_WIDTH  alu_result_mem[ADDR_WIDTH+1:2]
ram_wdata  out  32  write_data_memory_mem
ram_rdata  in  32  RAM read data
misaligned_err  out  1  sticky: set if any access had alu_result_mem[1:0] != 0

Behaviour:
- Only one clock (clk). rst is synchronous, active-high.
- Reset, or rst asserted mid-access:
  - state = IDLE, cnt = 0, data_from_memory_mem = 0, misaligned_err = 0.
  - ram_en = ram_we = 0.
  - data_ready_mem = 1 while rst is high.
  - Any in-flight access is abandoned; no further RAM strobes are issued for it.
- req = memread_mem | memwrite_mem. A store takes priority if both are high; on a store, data_from_memory_mem is unchanged.
- IDLE:
  - req = 0: data_ready_mem = 1, no RAM activity.
  - req = 1 (combinational, same cycle):
    - data_ready_mem = 0.
    - ram_en = 1; ram_we = memwrite_mem.
    - ram_addr and ram_wdata are driven from the inputs.
    - Next state = WAIT, cnt = 1.
  - misaligned_err is set on the issue cycle if alu_result_mem[1:0] != 0. The access still proceeds with the low bits dropped.
- WAIT:
  - data_ready_mem = 0, ram_en = ram_we = 0.
  - Load: when cnt == READ_LATENCY, capture ram_rdata into data_from_memory_mem and go to DONE; otherwise cnt += 1.
  - Store: when cnt == WRITE_LATENCY, go to DONE; otherwise cnt += 1.
  - cnt is 4 bits and never wraps within the legal latency range.
  - Request inputs are ignored in WAIT; they are stable because the pipeline is stalled.
- DONE:
  - data_ready_mem = 1.
  - If alu_ready = 1: the pipeline advances this edge; next state = IDLE.
  - If alu_ready = 0: remain in DONE and hold data_from_memory_mem, so MEM/WB still captures the correct data later.
- Back-to-back memory instructions: the request lines may stay high across DONE->IDLE. The IDLE arrival is treated as a new access, because DONE guarantees the EX/MEM register advanced.
- Load timing:
  - Request first seen in cycle 0.
  - data_ready_mem is low for cycles 0..READ_LATENCY.
  - In cycle READ_LATENCY+1, data_ready_mem is high and the data is valid.
  - Total cost: READ_LATENCY+1 stall cycles.
- Store timing: WRITE_LATENCY+1 stall cycles.
- A flushed (NOP) instruction has req = 0 and incurs no stall.

Test Plan:
- Reset: assert rst with memread_mem = 1 -> data_ready_mem = 1, ram_en = 0, data_from_memory_mem = 0, misaligned_err = 0. Deassert rst -> access starts the next cycle.
- Load, READ_LATENCY = 2: memread at addr 0x40, RAM returns 0xDEADBEEF 2 cycles after ram_en.
  - ram_en = 1 with ram_addr = 0x10 in cycle 0.
  - data_ready_mem = 0 in cycles 0-2; = 1 in cycle 3.
  - data_from_memory_mem = 0xDEADBEEF in cycle 3.
- Store, WRITE_LATENCY = 1: memwrite, addr 0x8, data 0x12345678.
  - Single cycle with ram_en = ram_we = 1, ram_addr = 2, ram_wdata = 0x12345678.
  - data_ready_mem low for 2 cycles, high in cycle 2.
  - data_from_memory_mem unchanged.
- Back-to-back: load, then store with memread/memwrite never both low.
  - Two distinct ram_en pulses.
  - data_ready_mem high for exactly one cycle between them.
- alu_ready = 0 during DONE for 3 cycles -> state holds DONE, data_ready_mem = 1, load data stable, no new ram_en. Set alu_ready = 1 -> IDLE.
- Mid-access reset and misalignment:
  - Load to 0x43 sets misaligned_err = 1 and ram_addr = 0x10.
  - Asserting rst in WAIT returns to IDLE, no data capture, misaligned_err cleared.
